// File: rtl/comparator_4bit.sv
// rtl/comparator_4bit.sv - registered 4-bit magnitude comparator stage with cascade inputs
module comparator_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LT_IN,
  input  logic       EQ_IN,
  input  logic       GT_IN,
  output logic       LT_OUT,
  output logic       EQ_OUT,
  output logic       GT_OUT,
  input  logic [3:0] A,
  input  logic [3:0] B
);

  logic [3:0] bit_eq;
  logic [3:0] bit_gt;
  logic [3:0] bit_lt;
  logic       a_gt_b;
  logic       a_lt_b;
  logic       lt_next;
  logic       eq_next;
  logic       gt_next;

  // Per-bit equality (xnor) and strict greater/less terms.
  always_comb begin
    bit_eq = ~(A ^ B);
    bit_gt = A & ~B;
    bit_lt = ~A & B;
  end

  // MSB-first decision: a lower bit only counts if every higher bit is equal.
  always_comb begin
    a_gt_b = bit_gt[3]
           | (bit_eq[3] & bit_gt[2])
           | (bit_eq[3] & bit_eq[2] & bit_gt[1])
           | (bit_eq[3] & bit_eq[2] & bit_eq[1] & bit_gt[0]);
    a_lt_b = bit_lt[3]
           | (bit_eq[3] & bit_lt[2])
           | (bit_eq[3] & bit_eq[2] & bit_lt[1])
           | (bit_eq[3] & bit_eq[2] & bit_eq[1] & bit_lt[0]);
  end

  // Resolve the next one-hot result; on a tie the cascade inputs decide, EQ_IN first,
  // so illegal cascade combinations collapse to a single flag.
  always_comb begin
    lt_next = 1'b0;
    eq_next = 1'b0;
    gt_next = 1'b0;
    if (a_gt_b) begin
      gt_next = 1'b1;
    end else if (a_lt_b) begin
      lt_next = 1'b1;
    end else if (EQ_IN) begin
      eq_next = 1'b1;
    end else if (GT_IN) begin
      gt_next = 1'b1;
    end else if (LT_IN) begin
      lt_next = 1'b1;
    end else begin
      eq_next = 1'b1;
    end
  end

  // Output register loads every edge; reset forces the EQ result at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LT_OUT <= 1'b0;
      EQ_OUT <= 1'b1;
      GT_OUT <= 1'b0;
    end else begin
      LT_OUT <= lt_next;
      EQ_OUT <= eq_next;
      GT_OUT <= gt_next;
    end
  end

endmodule

// File: tb/tb_comparator_4bit.sv
// tb/tb_comparator_4bit.sv - self-checking bench for comparator_4bit
module tb_comparator_4bit;

  logic       clk;
  logic       rst_n;
  logic       LT_IN;
  logic       EQ_IN;
  logic       GT_IN;
  logic       LT_OUT;
  logic       EQ_OUT;
  logic       GT_OUT;
  logic [3:0] A;
  logic [3:0] B;

  int         n_checks;
  int         n_fail;
  logic [2:0] exp_q;

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  comparator_4bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .LT_IN  (LT_IN),
    .EQ_IN  (EQ_IN),
    .GT_IN  (GT_IN),
    .LT_OUT (LT_OUT),
    .EQ_OUT (EQ_OUT),
    .GT_OUT (GT_OUT),
    .A      (A),
    .B      (B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer magnitude compare, tie broken by cascade priority EQ, GT, LT.
  function automatic logic [2:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] c);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    if (ia > ib) return R_GT;
    if (ia < ib) return R_LT;
    if (c[1]) return R_EQ;
    if (c[0]) return R_GT;
    if (c[2]) return R_LT;
    return R_EQ;
  endfunction

  task automatic check(input string tag, input logic [2:0] expv);
    logic [2:0] obs;
    obs = {LT_OUT, EQ_OUT, GT_OUT};
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed LT/EQ/GT=%b expected=%b (A=%h B=%h cas=%b%b%b)",
             tag, obs, expv, A, B, LT_IN, EQ_IN, GT_IN);
    end
  endtask

  // Apply inputs at the falling edge, confirm the old result still holds,
  // then confirm the new result one edge later. c = {LT_IN, EQ_IN, GT_IN}.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c,
                      input string tag);
    @(negedge clk);
    A = a;
    B = b;
    {LT_IN, EQ_IN, GT_IN} = c;
    #1 check({tag, "_hold"}, exp_q);
    exp_q = ref_model(a, b, c);
    @(posedge clk);
    #1 check(tag, exp_q);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    A        = 4'hF;
    B        = 4'h0;
    {LT_IN, EQ_IN, GT_IN} = 3'b010;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", R_EQ);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_held", R_EQ);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = R_EQ;
    @(posedge clk);
    #1 check("reset_release_load", R_GT);
    exp_q = R_GT;

    // Equality with default cascade.
    step(4'h0, 4'h0, 3'b010, "eq_00");
    step(4'hC, 4'hC, 3'b010, "eq_cc");

    // Magnitude.
    step(4'h4, 4'hC, 3'b010, "lt_4c");
    step(4'hF, 4'hC, 3'b010, "gt_fc");
    step(4'hF, 4'h7, 3'b010, "gt_f7");
    step(4'h5, 4'h8, 3'b010, "lt_58_msb");

    // Cascade pass-through on a tie.
    step(4'hA, 4'hA, 3'b001, "cas_gt");
    step(4'hA, 4'hA, 3'b100, "cas_lt");
    step(4'hA, 4'hA, 3'b000, "cas_none");
    step(4'hA, 4'hA, 3'b101, "cas_gt_lt");
    step(4'hA, 4'hA, 3'b111, "cas_all");
    for (int c = 0; c < 8; c++) begin
      step(4'h2, 4'h3, 3'(c), "cas_ignored_lt");
    end

    // Exhaustive sweep of operands and cascade combinations.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 8; c++) begin
          step(4'(a), 4'(b), 3'(c), "sweep");
        end
      end
    end

    // Random vectors.
    for (int i = 0; i < 100; i++) begin
      step(4'($urandom), 4'($urandom), 3'($urandom), "random");
    end

    // Mid-operation reset pulse shorter than a clock while GT is held.
    step(4'hF, 4'h7, 3'b010, "hold_gt");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrst_low", R_EQ);
    #1 rst_n = 1'b1;
    #1 check("midrst_released", R_EQ);
    @(posedge clk);
    #1 check("midrst_reload_gt", R_GT);
    exp_q = R_GT;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
